// File: rtl/mem_wait_bridge_pkg.sv
// Shared types and helpers for the memory wait-state bridge.
package mem_wait_pkg;

    // Transaction phases of the bridge.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2,
        RESP  = 2'd3
    } mwb_state_t;

    // Read data returned to the bus when the SRAM never acknowledges.
    localparam logic [31:0] MWB_ERR_DATA = 32'hFFFF_FFFF;

    // Width of the shared down-counter: it must hold both the wait-state
    // reload and the timeout reload. At least one bit is always returned.
    function automatic int mwb_cnt_width(input int wait_cycles, input int timeout);
        int max_val;
        max_val = (wait_cycles > timeout) ? wait_cycles : timeout;
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_wait_bridge_counter.sv
// Loadable down-counter with a zero flag. Load has priority over decrement,
// and the count saturates at zero instead of wrapping.
module mwb_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;

    // Count register: reload, decrement or hold.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/mem_wait_bridge.sv
// Bridge from the single-cycle bus memory port to a req/ack SRAM port.
// Inserts WAIT_CYCLES fixed wait states, then holds sram_req until ack or
// until TIMEOUT cycles pass, stalling the bus for the whole transaction.
module mem_wait_bridge
    import mem_wait_pkg::*;
#(
    parameter int          WAIT_CYCLES = 2,
    parameter int          TIMEOUT     = 16,
    parameter logic [31:0] ERR_DATA    = MWB_ERR_DATA
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        data_access,
    input  logic [31:0] addr_mem,
    input  logic [31:0] data_write_mem,
    input  logic [3:0]  data_we_mem,
    output logic [31:0] data_read_mem,
    output logic        stall,
    output logic        bus_error,
    output logic        sram_req,
    output logic [29:0] sram_addr,
    output logic [3:0]  sram_we,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    input  logic        sram_ack
);

    localparam int            CW        = mwb_cnt_width(WAIT_CYCLES, TIMEOUT);
    localparam logic [CW-1:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;
    localparam logic [CW-1:0] TO_LOAD   = CW'(TIMEOUT - 1);

    mwb_state_t    state_q, state_d;
    logic [29:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    we_q, we_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          cnt_load;
    logic [CW-1:0] cnt_load_val;
    logic          cnt_dec;
    logic          cnt_zero;

    // Byte lanes travel on sram_we, so the low address bits are dropped.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^addr_mem[1:0];

    // One counter serves both the wait phase and the ack timeout.
    mwb_down_counter #(
        .WIDTH (CW)
    ) u_counter (
        .clk_i      (clock),
        .srst_i     (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic, request latching, counter control and read capture.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        cnt_load     = 1'b0;
        cnt_load_val = WAIT_LOAD;
        cnt_dec      = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_access) begin
                    addr_d   = addr_mem[31:2];
                    wdata_d  = data_write_mem;
                    we_d     = data_we_mem;
                    cnt_load = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d      = ISSUE;
                        cnt_load_val = TO_LOAD;
                    end else begin
                        state_d      = WAIT;
                        cnt_load_val = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_zero) begin
                    state_d      = ISSUE;
                    cnt_load     = 1'b1;
                    cnt_load_val = TO_LOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ISSUE: begin
                if (sram_ack) begin
                    if (we_q == 4'b0000) begin
                        rdata_d = sram_rdata;
                    end
                    state_d = RESP;
                end else if (cnt_zero) begin
                    rdata_d = ERR_DATA;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RESP: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sram_req      = (state_q == ISSUE);
    assign sram_addr     = addr_q;
    assign sram_we       = we_q;
    assign sram_wdata    = wdata_q;
    assign data_read_mem = rdata_q;
    assign bus_error     = (state_q == RESP) && err_q;
    assign stall         = !reset && ((state_q == WAIT) || (state_q == ISSUE) ||
                                      ((state_q == IDLE) && data_access));

endmodule

// File: tb/tb_mem_wait_bridge.sv
// Directed bench for mem_wait_bridge: one instance with two wait states and
// one with none. Inputs change on the falling edge; outputs are sampled 1ns
// later, so the combinational stall sees the freshly driven strobe.
module tb_mem_wait_bridge;

    logic        clock = 1'b0;
    logic        reset;

    // Instance A: WAIT_CYCLES = 2, TIMEOUT = 16
    logic        a_access;
    logic [31:0] a_addr, a_wdata_in, a_rdata_out, a_sram_wdata, a_sram_rdata;
    logic [3:0]  a_we_in, a_sram_we;
    logic        a_stall, a_berr, a_req, a_ack;
    logic [29:0] a_sram_addr;

    // Instance B: WAIT_CYCLES = 0, TIMEOUT = 16
    logic        b_access;
    logic [31:0] b_addr, b_wdata_in, b_rdata_out, b_sram_wdata, b_sram_rdata;
    logic [3:0]  b_we_in, b_sram_we;
    logic        b_stall, b_berr, b_req, b_ack;
    logic [29:0] b_sram_addr;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    mem_wait_bridge #(.WAIT_CYCLES(2), .TIMEOUT(16)) u_dut_a (
        .clock          (clock),
        .reset          (reset),
        .data_access    (a_access),
        .addr_mem       (a_addr),
        .data_write_mem (a_wdata_in),
        .data_we_mem    (a_we_in),
        .data_read_mem  (a_rdata_out),
        .stall          (a_stall),
        .bus_error      (a_berr),
        .sram_req       (a_req),
        .sram_addr      (a_sram_addr),
        .sram_we        (a_sram_we),
        .sram_wdata     (a_sram_wdata),
        .sram_rdata     (a_sram_rdata),
        .sram_ack       (a_ack)
    );

    mem_wait_bridge #(.WAIT_CYCLES(0), .TIMEOUT(16)) u_dut_b (
        .clock          (clock),
        .reset          (reset),
        .data_access    (b_access),
        .addr_mem       (b_addr),
        .data_write_mem (b_wdata_in),
        .data_we_mem    (b_we_in),
        .data_read_mem  (b_rdata_out),
        .stall          (b_stall),
        .bus_error      (b_berr),
        .sram_req       (b_req),
        .sram_addr      (b_sram_addr),
        .sram_we        (b_sram_we),
        .sram_wdata     (b_sram_wdata),
        .sram_rdata     (b_sram_rdata),
        .sram_ack       (b_ack)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge.
    task automatic step();
        @(negedge clock);
    endtask

    initial begin
        int  req_cnt;
        bit  done;
        int  ph;
        logic [29:0] exp_addr;

        reset = 1'b1;
        a_access = 1'b1; a_addr = 32'h0; a_wdata_in = 32'h0; a_we_in = 4'h0;
        a_sram_rdata = 32'h0; a_ack = 1'b0;
        b_access = 1'b0; b_addr = 32'h0; b_wdata_in = 32'h0; b_we_in = 4'h0;
        b_sram_rdata = 32'h0; b_ack = 1'b0;

        // ---------------- reset state ----------------
        step(); step();
        #1;
        check("rst_stall_forced", {31'b0, a_stall}, 32'd0);
        check("rst_rdata", a_rdata_out, 32'h0);
        check("rst_berr", {31'b0, a_berr}, 32'd0);
        check("rst_req", {31'b0, a_req}, 32'd0);
        check("rst_addr", {2'b0, a_sram_addr}, 32'h0);
        check("rst_we", {28'b0, a_sram_we}, 32'h0);
        check("rst_wdata", a_sram_wdata, 32'h0);
        $display("txn reset: done");
        step();
        reset = 1'b0; a_access = 1'b0;

        // ---------------- read, W=2, L=1 ----------------
        step();
        a_access = 1'b1; a_addr = 32'h0000_1008; a_we_in = 4'h0; #1;
        check("rd_stall_N", {31'b0, a_stall}, 32'd1);
        check("rd_req_N", {31'b0, a_req}, 32'd0);
        step(); a_access = 1'b0; #1;
        check("rd_stall_N1", {31'b0, a_stall}, 32'd1);
        check("rd_req_N1", {31'b0, a_req}, 32'd0);
        check("rd_sram_addr", {2'b0, a_sram_addr}, 32'h402);
        step(); #1;
        check("rd_stall_N2", {31'b0, a_stall}, 32'd1);
        check("rd_req_N2", {31'b0, a_req}, 32'd0);
        step();
        a_ack = 1'b1; a_sram_rdata = 32'hCAFE_F00D; #1;
        check("rd_stall_N3", {31'b0, a_stall}, 32'd1);
        check("rd_req_N3", {31'b0, a_req}, 32'd1);
        step(); a_ack = 1'b0; a_sram_rdata = 32'h0; #1;
        check("rd_stall_resp", {31'b0, a_stall}, 32'd0);
        check("rd_req_resp", {31'b0, a_req}, 32'd0);
        check("rd_data", a_rdata_out, 32'hCAFE_F00D);
        check("rd_berr", {31'b0, a_berr}, 32'd0);
        $display("txn read addr=0x00001008 data=0x%08h", a_rdata_out);

        // ---------------- timeout, W=2, no ack ----------------
        step();
        a_access = 1'b1; a_addr = 32'h0000_2000; #1;
        req_cnt = 0; done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            step(); a_access = 1'b0; #1;
            if (a_req) req_cnt++;
            else if (req_cnt > 0) done = 1'b1;
        end
        check("to_bound_reached", {31'b0, done}, 32'd1);
        check("to_req_cycles", req_cnt, 32'd16);
        check("to_berr_pulse", {31'b0, a_berr}, 32'd1);
        check("to_err_data", a_rdata_out, 32'hFFFF_FFFF);
        check("to_stall", {31'b0, a_stall}, 32'd0);
        step(); #1;
        check("to_berr_one_cycle", {31'b0, a_berr}, 32'd0);
        $display("txn timeout req_cycles=%0d", req_cnt);

        // ---------------- reset during ISSUE, late ack ----------------
        step();
        a_access = 1'b1; a_addr = 32'h0000_3004; #1;
        step(); a_access = 1'b0;
        step();
        step(); #1;
        check("rm_in_issue", {31'b0, a_req}, 32'd1);
        step(); reset = 1'b1; #1;
        check("rm_stall_forced", {31'b0, a_stall}, 32'd0);
        step(); reset = 1'b0; a_ack = 1'b1; a_sram_rdata = 32'hDEAD_BEEF; #1;
        check("rm_req_low", {31'b0, a_req}, 32'd0);
        check("rm_stall_low", {31'b0, a_stall}, 32'd0);
        step(); a_ack = 1'b0; a_sram_rdata = 32'h0; #1;
        check("rm_late_ack_rdata", a_rdata_out, 32'h0);
        check("rm_no_resp_berr", {31'b0, a_berr}, 32'd0);
        check("rm_still_idle", {31'b0, a_stall}, 32'd0);
        $display("txn reset-mid late_ack rdata=0x%08h", a_rdata_out);

        // ---------------- back-to-back, data_access held high ----------------
        // Expected period W+3 = 5: IDLE, WAIT, WAIT, ISSUE(ack), RESP.
        for (int c = 0; c < 15; c++) begin
            step();
            ph = c % 5;
            a_access = 1'b1;
            a_addr = 32'h0000_0100 + 32'(c) * 4;
            a_ack = (ph == 3);
            a_sram_rdata = 32'hA500_0000 + 32'(c);
            #1;
            check("b2b_stall", {31'b0, a_stall}, (ph != 4) ? 32'd1 : 32'd0);
            check("b2b_req", {31'b0, a_req}, (ph == 3) ? 32'd1 : 32'd0);
            if (ph >= 1 && ph <= 3) begin
                exp_addr = 30'h40 + 30'(c - ph);
                check("b2b_addr_stable", {2'b0, a_sram_addr}, {2'b0, exp_addr});
            end
            if (ph == 4) begin
                check("b2b_rdata", a_rdata_out, 32'hA500_0000 + 32'(c - 1));
                $display("txn b2b read cycle=%0d data=0x%08h", c, a_rdata_out);
            end
        end
        step(); a_access = 1'b0; a_ack = 1'b0;

        // ---------------- W=0: read to preset data, then write ----------------
        b_access = 1'b1; b_addr = 32'h0000_0010; b_we_in = 4'h0; #1;
        check("w0_rd_stall_N", {31'b0, b_stall}, 32'd1);
        step(); b_access = 1'b0; b_ack = 1'b1; b_sram_rdata = 32'h55AA_55AA; #1;
        check("w0_rd_req_N1", {31'b0, b_req}, 32'd1);
        step(); b_ack = 1'b0; b_sram_rdata = 32'h0; #1;
        check("w0_rd_data", b_rdata_out, 32'h55AA_55AA);
        $display("txn w0 read data=0x%08h", b_rdata_out);

        step();
        b_access = 1'b1; b_addr = 32'h0000_0020; b_we_in = 4'b0011;
        b_wdata_in = 32'h1234_5678; #1;
        check("wr_stall_N", {31'b0, b_stall}, 32'd1);
        check("wr_req_N", {31'b0, b_req}, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            step();
            b_access = 1'b0; b_we_in = 4'h0; b_wdata_in = 32'h0;
            b_ack = (k == 3); b_sram_rdata = 32'hBAD0_BAD0;
            #1;
            check("wr_stall", {31'b0, b_stall}, 32'd1);
            check("wr_req", {31'b0, b_req}, 32'd1);
            check("wr_we", {28'b0, b_sram_we}, 32'h3);
            check("wr_wdata", b_sram_wdata, 32'h1234_5678);
            check("wr_addr", {2'b0, b_sram_addr}, 32'h8);
        end
        step(); b_ack = 1'b0; b_sram_rdata = 32'h0; #1;
        check("wr_stall_resp", {31'b0, b_stall}, 32'd0);
        check("wr_req_resp", {31'b0, b_req}, 32'd0);
        check("wr_rdata_unchanged", b_rdata_out, 32'h55AA_55AA);
        check("wr_berr", {31'b0, b_berr}, 32'd0);
        $display("txn w0 write we=0011 wdata=0x12345678");

        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
